// File: rtl/trace_commit_encoder.sv
// ---------------------------------------------------------------------------
// trace_commit_encoder
//
// Turns CPU writeback activity into a byte stream of commit records that a
// host script converts back into the unit-test bench trace lines.
//
// Each sampled cycle (after the warm-up window, with en=1) gets the next
// cycle index. If a writeback strobe is active in that cycle, exactly one
// record is built, with priority GPR > HI/LO > CP0. The record is queued in
// a small FIFO and then serialized big-endian, one byte per handshake.
//
// Record layouts on the wire:
//   GPR   : 0x01, index[4], addr[1], data[4]   (10 bytes)
//   HI/LO : 0x02, index[4], hi[4],   lo[4]     (13 bytes)
//   CP0   : 0x03, index[4], addr[1], data[4]   (10 bytes)
// The host infers skipped cycles from gaps in the index sequence.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   en                trace enable; 0 = no sampling, index holds
//   reg_write_*       GPR writeback strobe / address / data
//   hilo_we, hi_data, lo_data   HI/LO writeback strobe and values
//   cp0_we, cp0_waddr, cp0_wdata CP0 writeback strobe / address / data
//   tx_data, tx_valid, tx_ready byte stream towards UART / debug link
//   overflow          sticky, set when a record was dropped (FIFO full)
//   dropped_count     number of dropped records, saturates at 0xFFFF
//   cycle_index       last assigned cycle index
// ---------------------------------------------------------------------------
module trace_commit_encoder #(
    parameter int FIFO_DEPTH  = 16,
    parameter int START_DELAY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        reg_write_enable,
    input  logic [4:0]  reg_write_addr,
    input  logic [31:0] reg_write_data,
    input  logic        hilo_we,
    input  logic [31:0] hi_data,
    input  logic [31:0] lo_data,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] dropped_count,
    output logic [31:0] cycle_index
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 + 32 + 64;           // {type, index, payload}
    localparam logic [PW:0]  DEPTH_C    = (PW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]  WARM_LIMIT = 16'(START_DELAY);

    localparam logic [1:0] REC_GPR  = 2'd1;
    localparam logic [1:0] REC_HILO = 2'd2;
    localparam logic [1:0] REC_CP0  = 2'd3;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // -----------------------------------------------------------------------
    // Warm-up window and cycle index
    // -----------------------------------------------------------------------
    logic [15:0] warm_cnt;
    logic        warm_done;
    logic        sample;
    logic [31:0] index_next;

    assign warm_done  = (warm_cnt == WARM_LIMIT);
    assign sample     = warm_done & en;
    assign index_next = cycle_index + 32'd1;   // wraps 0xFFFFFFFF -> 0

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_cnt    <= '0;
            cycle_index <= '0;
        end else begin
            if (!warm_done)
                warm_cnt <= warm_cnt + 16'd1;
            if (sample)
                cycle_index <= index_next;
        end
    end

    // -----------------------------------------------------------------------
    // Event select: one record per cycle, lower-priority strobes are ignored
    // -----------------------------------------------------------------------
    logic        ev_valid;
    logic [1:0]  ev_type;
    logic [63:0] ev_payload;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ev_valid   = 1'b0;
        ev_type    = REC_GPR;
        ev_payload = '0;
        if (reg_write_enable) begin
            ev_valid   = 1'b1;
            ev_type    = REC_GPR;
            ev_payload = {27'd0, reg_write_addr, reg_write_data};
        end else if (hilo_we) begin
            ev_valid   = 1'b1;
            ev_type    = REC_HILO;
            ev_payload = {hi_data, lo_data};
        end else if (cp0_we) begin
            ev_valid   = 1'b1;
            ev_type    = REC_CP0;
            ev_payload = {27'd0, cp0_waddr, cp0_wdata};
        end
    end

    // -----------------------------------------------------------------------
    // Record FIFO
    // -----------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_full  = (fifo_count == DEPTH_C);
    assign fifo_empty = (fifo_count == '0);
    assign push_req   = sample & ev_valid;
    // Fullness is judged before any same-edge pop.
    assign push       = push_req & ~fifo_full;
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ev_type, index_next, ev_payload};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
                if (dropped_count != 16'hFFFF)
                    dropped_count <= dropped_count + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Serializer: records are left-aligned in a 13-byte shift register so the
    // current byte is always the top byte.
    // -----------------------------------------------------------------------
    state_t       state;
    state_t       state_next;
    logic         load;
    logic [103:0] shreg;
    logic [3:0]   byte_cnt;
    logic [103:0] load_rec;
    logic [3:0]   load_len;

    always_comb begin
        if (head[97:96] == REC_HILO) begin
            load_rec = {8'h02, head[95:64], head[63:0]};
            load_len = 4'd13;
        end else begin
            load_rec = {6'd0, head[97:96], head[95:64], head[39:0], 24'd0};
            load_len = 4'd10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shreg[103:96];
                if (tx_ready && byte_cnt == 4'd1) begin
                    // Last byte accepted: reload immediately if more are queued.
                    if (!fifo_empty)
                        load = 1'b1;
                    else
                        state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pop = load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shreg    <= load_rec;
            byte_cnt <= load_len;
        end else if (state == S_SEND && tx_ready) begin
            shreg    <= {shreg[95:0], 8'h00};
            byte_cnt <= byte_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_trace_commit_encoder.sv
// ---------------------------------------------------------------------------
// tb_trace_commit_encoder
//
// Directed bench for trace_commit_encoder. Inputs change on the falling edge;
// a monitor samples the byte stream shortly after each falling edge, collects
// every accepted byte with its cycle number, and checks that a stalled byte
// stays valid and unchanged. Expected records are hand-built from the
// stimulus values.
// ---------------------------------------------------------------------------
module tb_trace_commit_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        hilo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [15:0] dropped_count;
    logic [31:0] cycle_index;

    always #5 clk = ~clk;

    trace_commit_encoder #(
        .FIFO_DEPTH  (16),
        .START_DELAY (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .reg_write_enable (reg_write_enable),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .hilo_we          (hilo_we),
        .hi_data          (hi_data),
        .lo_data          (lo_data),
        .cp0_we           (cp0_we),
        .cp0_waddr        (cp0_waddr),
        .cp0_wdata        (cp0_wdata),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .overflow         (overflow),
        .dropped_count    (dropped_count),
        .cycle_index      (cycle_index)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stream monitor
    // -----------------------------------------------------------------------
    logic [7:0] rx   [$];
    int         rx_t [$];
    int         cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1'b1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                rx.push_back(tx_data);
                rx_t.push_back(cyc);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // -----------------------------------------------------------------------
    // Helpers (the main thread always sits just after a falling edge)
    // -----------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        reg_write_enable = 1'b0;
        hilo_we          = 1'b0;
        cp0_we           = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        en       = 1'b1;
        tx_ready = 1'b1;
        clear_strobes();
        step();
        step();
        rx.delete();
        rx_t.delete();
        rst = 1'b1;             // next rising edge is warm-up edge 1
    endtask

    task automatic warm_up();
        repeat (5) step();
    endtask

    task automatic gpr(input logic [4:0] addr, input logic [31:0] data);
        reg_write_enable = 1'b1;
        reg_write_addr   = addr;
        reg_write_data   = data;
        step();
        clear_strobes();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            step();
            k++;
        end
        check("rx_count", rx.size(), n);
    endtask

    function automatic logic [31:0] get_byte(input int i);
        if (i < rx.size())
            return {24'd0, rx[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_short(input string tag, input int base, input logic [7:0] typ,
                               input logic [31:0] idx, input logic [7:0] addr,
                               input logic [31:0] data);
        logic [79:0] r;
        r = {typ, idx, addr, data};
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_b%0d", tag, i), get_byte(base + i), {24'd0, r[79 - 8*i -: 8]});
    endtask

    task automatic check_hilo(input string tag, input int base, input logic [31:0] idx,
                              input logic [31:0] hi, input logic [31:0] lo);
        logic [103:0] r;
        r = {8'h02, idx, hi, lo};
        for (int i = 0; i < 13; i++)
            check($sformatf("%s_b%0d", tag, i), get_byte(base + i), {24'd0, r[103 - 8*i -: 8]});
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst            = 1'b0;
        en             = 1'b1;
        tx_ready       = 1'b1;
        reg_write_addr = '0;
        reg_write_data = '0;
        hi_data        = '0;
        lo_data        = '0;
        cp0_waddr      = '0;
        cp0_wdata      = '0;
        clear_strobes();
        step();

        // Reset values
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_dropped", dropped_count, 16'd0);
        check("rst_index", cycle_index, 32'd0);

        // GPR write on the 3rd post-warm-up edge, latency, en=0 hold
        do_reset();
        warm_up();
        repeat (2) step();
        gpr(5'd5, 32'h1234_5678);
        check("t1_index", cycle_index, 32'd3);
        check("t1_valid_same_edge", tx_valid, 1'b0);
        step();
        check("t1_valid_next_edge", tx_valid, 1'b1);
        check("t1_first_byte", tx_data, 8'h01);
        en               = 1'b0;
        reg_write_enable = 1'b1;
        reg_write_addr   = 5'd9;
        reg_write_data   = 32'h0BAD_0BAD;
        repeat (3) step();
        check("t1_en_hold", cycle_index, 32'd4);
        clear_strobes();
        en = 1'b1;
        wait_bytes(10, 40);
        repeat (5) step();
        check("t1_no_extra", rx.size(), 10);
        check_short("t1", 0, 8'h01, 32'd3, 8'h05, 32'h1234_5678);

        // Strobes during warm-up ignored; first sampled edge is index 1;
        // all three strobes at index 2 give a GPR record only
        do_reset();
        for (int i = 0; i < 5; i++) begin
            reg_write_enable = 1'b1;
            reg_write_addr   = 5'(i + 10);
            reg_write_data   = 32'h7700_0000 + i;
            hilo_we          = 1'b1;
            step();
        end
        clear_strobes();
        gpr(5'd1, 32'hDEAD_BEEF);
        reg_write_enable = 1'b1;
        reg_write_addr   = 5'd7;
        reg_write_data   = 32'hCAFE_F00D;
        hilo_we          = 1'b1;
        hi_data          = 32'h1111_1111;
        lo_data          = 32'h2222_2222;
        cp0_we           = 1'b1;
        cp0_waddr        = 5'd3;
        cp0_wdata        = 32'h3333_3333;
        step();
        clear_strobes();
        check("t2_overflow", overflow, 1'b0);
        check("t2_dropped", dropped_count, 16'd0);
        wait_bytes(20, 60);
        repeat (5) step();
        check("t2_no_extra", rx.size(), 20);
        check_short("t2_idx1", 0, 8'h01, 32'd1, 8'h01, 32'hDEAD_BEEF);
        check_short("t2_idx2", 10, 8'h01, 32'd2, 8'h07, 32'hCAFE_F00D);

        // HI/LO then CP0 on consecutive edges, streamed back to back
        do_reset();
        warm_up();
        hilo_we = 1'b1;
        hi_data = 32'hAABB_CCDD;
        lo_data = 32'h1122_3344;
        step();
        clear_strobes();
        cp0_we    = 1'b1;
        cp0_waddr = 5'd12;
        cp0_wdata = 32'h0000_FF01;
        step();
        clear_strobes();
        wait_bytes(23, 60);
        check_hilo("t4_hilo", 0, 32'd1, 32'hAABB_CCDD, 32'h1122_3344);
        check_short("t4_cp0", 13, 8'h03, 32'd2, 8'h0C, 32'h0000_FF01);
        if (rx_t.size() >= 23) begin
            check("t4_no_bubble", rx_t[13] - rx_t[12], 1);
            check("t4_span", rx_t[22] - rx_t[0], 22);
        end

        // Overflow: 18 writes while the sink stalls, then drain with stalls
        do_reset();
        warm_up();
        tx_ready = 1'b0;
        for (int i = 1; i <= 18; i++)
            gpr(5'(i), 32'hA500_0000 | i);
        check("t5_overflow", overflow, 1'b1);
        check("t5_dropped", dropped_count, 16'd1);
        check("t5_stall_valid", tx_valid, 1'b1);
        check("t5_stall_type", tx_data, 8'h01);
        repeat (3) step();
        begin
            int k = 0;
            while (rx.size() < 170 && k < 800) begin
                tx_ready = (k % 3 != 2);
                step();
                k++;
            end
        end
        tx_ready = 1'b1;
        check("t5_rx_count", rx.size(), 170);
        for (int r = 0; r < 17; r++)
            check_short($sformatf("t5_rec%0d", r + 1), r * 10, 8'h01, r + 1,
                        8'((r + 1) & 31), 32'hA500_0000 | (r + 1));
        repeat (10) step();
        check("t5_no_extra", rx.size(), 170);
        check("t5_overflow_sticky", overflow, 1'b1);

        // Reset in the middle of a record, with a second record queued
        do_reset();
        warm_up();
        gpr(5'd2, 32'h1122_3344);
        gpr(5'd3, 32'h5566_7788);
        wait_bytes(4, 30);
        check("t6_mid_valid", tx_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_async_valid", tx_valid, 1'b0);
        check("t6_async_data", tx_data, 8'h00);
        check("t6_async_index", cycle_index, 32'd0);
        step();
        step();
        rx.delete();
        rx_t.delete();
        rst = 1'b1;
        warm_up();
        check("t6_no_residue", rx.size(), 0);
        gpr(5'd4, 32'h9999_0001);
        check("t6_index", cycle_index, 32'd1);
        wait_bytes(10, 40);
        repeat (5) step();
        check("t6_no_extra", rx.size(), 10);
        check_short("t6_rec", 0, 8'h01, 32'd1, 8'h04, 32'h9999_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
